// File: rtl/inlet_dose_sequencer.sv
// inlet_dose_sequencer
//   Timed controller for the three inlets (soln1..soln3) of the mixing
//   netlist. An accepted start opens every inlet whose duration is non-zero.
//   Each inlet closes on its own after its programmed number of cycles. When
//   the longest inlet has closed, a settle interval lets the mixer chain
//   flush. The block then reports completion for one cycle.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a run (accepted only in IDLE with abort low)
//   abort             : terminate a run in DOSE/SETTLE/DONE immediately
//   dur1..dur3        : inlet open cycles, latched at the accepted start
//   settle            : post-dose settle cycles, latched at the accepted start
//   valve1..valve3    : registered inlet-open outputs
//   busy              : run in progress (DOSE, SETTLE, DONE)
//   done              : one-cycle pulse, run completed normally
//   aborted           : one-cycle pulse, run terminated by abort
//   run_count         : completed-run counter, wraps at 2^RUN_W
//
// Handshake: start is a level sampled on every rising edge; it takes effect
// only when the block is idle and abort is low. There is no queuing, so a
// start seen outside IDLE is dropped.

module inlet_dose_sequencer #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dur1,
    input  logic [CNT_W-1:0] dur2,
    input  logic [CNT_W-1:0] dur3,
    input  logic [CNT_W-1:0] settle,
    output logic             valve1,
    output logic             valve2,
    output logic             valve3,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [RUN_W-1:0] run_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DOSE   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    // Phase counter: holds remaining cycles of the current DOSE or SETTLE phase.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] settle_q;
    logic [CNT_W-1:0] settle_next;

    // Per-inlet down-counters; each inlet is timed independently.
    logic [CNT_W-1:0] dur_in     [3];
    logic [CNT_W-1:0] vcnt       [3];
    logic [CNT_W-1:0] vcnt_next  [3];
    logic [2:0]       valve_q;
    logic [2:0]       valve_next;

    logic [CNT_W-1:0] d12;
    logic [CNT_W-1:0] dmax;
    logic             accept;
    logic             kill;

    assign dur_in[0] = dur1;
    assign dur_in[1] = dur2;
    assign dur_in[2] = dur3;

    assign d12  = (dur1 > dur2) ? dur1 : dur2;
    assign dmax = (d12 > dur3) ? d12 : dur3;

    assign accept = (state == IDLE) && start && !abort;
    assign kill   = (state != IDLE) && abort;

    // Next-state and phase counter. A phase counter value of 1 marks the last
    // cycle of the phase, so a phase loaded with N lasts exactly N cycles and
    // the full 2^CNT_W-1 range is usable without wrap.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        settle_next = settle_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    settle_next = settle;
                    if (dmax != '0) begin
                        state_next = DOSE;
                        cnt_next   = dmax;
                    end else if (settle != '0) begin
                        state_next = SETTLE;
                        cnt_next   = settle;
                    end else begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end
                end
            end
            DOSE: begin
                if (cnt == CNT_W'(1)) begin
                    if (settle_q != '0) begin
                        state_next = SETTLE;
                        cnt_next   = settle_q;
                    end else begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (kill) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    // Inlet timing: a valve opens at the accept edge when its duration is
    // non-zero and closes after the cycle in which its counter reads 1.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            valve_next[k] = valve_q[k];
            vcnt_next[k]  = vcnt[k];
            if (accept) begin
                valve_next[k] = (dur_in[k] != '0);
                vcnt_next[k]  = dur_in[k];
            end else if (kill) begin
                valve_next[k] = 1'b0;
                vcnt_next[k]  = '0;
            end else if (valve_q[k]) begin
                vcnt_next[k] = vcnt[k] - CNT_W'(1);
                if (vcnt[k] == CNT_W'(1)) begin
                    valve_next[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            settle_q  <= '0;
            valve_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            run_count <= '0;
            for (int k = 0; k < 3; k++) begin
                vcnt[k] <= '0;
            end
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            settle_q <= settle_next;
            valve_q  <= valve_next;
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);
            aborted  <= kill;
            // An abort during DONE cancels the completion credit.
            if (state == DONE && !abort) begin
                run_count <= run_count + RUN_W'(1);
            end
            for (int k = 0; k < 3; k++) begin
                vcnt[k] <= vcnt_next[k];
            end
        end
    end

    assign valve1 = valve_q[0];
    assign valve2 = valve_q[1];
    assign valve3 = valve_q[2];

endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb_inlet_dose_sequencer
//   Directed bench for inlet_dose_sequencer with CNT_W=4, RUN_W=2 so that the
//   maximum duration and the run counter wrap are reachable quickly.
//   Each driver step sets the inputs sampled at the next rising edge and
//   pushes the output vector expected in the cycle after that edge. A monitor
//   pops one entry per falling edge and compares.
//   Output vector: {valve1, valve2, valve3, busy, done, aborted, run_count}.

module tb_inlet_dose_sequencer;

    localparam int CNT_W = 4;
    localparam int RUN_W = 2;
    localparam int VW    = 6 + RUN_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] dur1;
    logic [CNT_W-1:0] dur2;
    logic [CNT_W-1:0] dur3;
    logic [CNT_W-1:0] settle;
    logic             valve1;
    logic             valve2;
    logic             valve3;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [RUN_W-1:0] run_count;

    logic [VW-1:0]    exp_q[$];
    string            tag_q[$];
    int               total;
    int               bad;
    logic [RUN_W-1:0] rc;

    inlet_dose_sequencer #(
        .CNT_W(CNT_W),
        .RUN_W(RUN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .dur1     (dur1),
        .dur2     (dur2),
        .dur3     (dur3),
        .settle   (settle),
        .valve1   (valve1),
        .valve2   (valve2),
        .valve3   (valve3),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .run_count(run_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [VW-1:0] pack(input bit v1, input bit v2, input bit v3,
                                           input bit b, input bit dn, input bit ab,
                                           input logic [RUN_W-1:0] r);
        return {v1, v2, v3, b, dn, ab, r};
    endfunction

    task automatic step(input bit r, input bit s, input bit a,
                        input int d1, input int d2, input int d3, input int st,
                        input logic [VW-1:0] exp_v, input string tag);
        @(negedge clk);
        #1;
        rst    = r;
        start  = s;
        abort  = a;
        dur1   = CNT_W'(d1);
        dur2   = CNT_W'(d2);
        dur3   = CNT_W'(d3);
        settle = CNT_W'(st);
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
    endtask

    task automatic idle_steps(input int n, input bit s, input bit a, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, s, a, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, rc), tag);
        end
    endtask

    task automatic do_reset(input int n);
        rc = '0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, '0), "reset");
        end
    endtask

    // One run, cycle c = 1 is the first cycle after the accept edge.
    // abort_at / rst_at: cycle during which abort / rst is held (0 = never).
    // noise: pulse start and scramble the field inputs while the run is active.
    task automatic do_run(input int d1, input int d2, input int d3, input int s,
                          input int abort_at, input int rst_at, input bit noise,
                          input string tag);
        int dm;
        int t_done;
        int last;
        bit v1, v2, v3, b, dn, ab;
        logic [RUN_W-1:0] r;
        bit st_in, ab_in, rs_in;
        int i1, i2, i3, is;
        dm = (d1 > d2) ? d1 : d2;
        dm = (dm > d3) ? dm : d3;
        t_done = dm + s + 1;
        if (abort_at > 0)    last = abort_at + 1;
        else if (rst_at > 0) last = rst_at + 1;
        else                 last = t_done + 1;
        for (int c = 1; c <= last; c++) begin
            st_in = (c == 1) || (noise && (c % 2 == 0));
            ab_in = (abort_at > 0) && (c - 1 == abort_at);
            rs_in = (rst_at > 0) && (c - 1 == rst_at);
            if (c == 1 || !noise) begin
                i1 = d1; i2 = d2; i3 = d3; is = s;
            end else begin
                i1 = $urandom_range(0, 15);
                i2 = $urandom_range(0, 15);
                i3 = $urandom_range(0, 15);
                is = $urandom_range(0, 15);
            end
            if (abort_at > 0 && c == abort_at + 1) begin
                {v1, v2, v3, b, dn, ab, r} = pack(0, 0, 0, 0, 0, 1, rc);
            end else if (rst_at > 0 && c == rst_at + 1) begin
                {v1, v2, v3, b, dn, ab, r} = pack(0, 0, 0, 0, 0, 0, '0);
            end else begin
                v1 = (c <= d1);
                v2 = (c <= d2);
                v3 = (c <= d3);
                b  = (c <= t_done);
                dn = (c == t_done);
                ab = 1'b0;
                r  = (c <= t_done) ? rc : rc + RUN_W'(1);
            end
            step(rs_in, st_in, ab_in, i1, i2, i3, is, pack(v1, v2, v3, b, dn, ab, r), tag);
        end
        if (rst_at > 0)        rc = '0;
        else if (abort_at == 0) rc = rc + RUN_W'(1);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [VW-1:0] e;
        logic [VW-1:0] act;
        string         t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                act = {valve1, valve2, valve3, busy, done, aborted, run_count};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s @%0t: got v123/busy/done/abt/rc=%b required %b",
                             t, $time, act, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total  = 0;
        bad    = 0;
        rc     = '0;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        dur1   = '0;
        dur2   = '0;
        dur3   = '0;
        settle = '0;

        do_reset(2);
        idle_steps(2, 1'b0, 1'b0, "idle");

        do_run(3, 5, 2, 4, 0, 0, 1'b0, "basic");
        do_run(0, 0, 0, 0, 0, 0, 1'b0, "all_zero");
        do_run(4, 0, 0, 0, 0, 0, 1'b0, "dur2_zero");
        do_run(10, 10, 10, 5, 4, 0, 1'b0, "abort_dose");
        do_run(2, 1, 3, 2, 0, 0, 1'b0, "after_abort");
        do_run(3, 5, 2, 4, 0, 0, 1'b1, "ignored_start");
        idle_steps(1, 1'b1, 1'b1, "start_with_abort");
        idle_steps(3, 1'b0, 1'b0, "idle_after_rej");
        idle_steps(2, 1'b0, 1'b1, "abort_in_idle");
        do_run(1, 1, 1, 3, 0, 0, 1'b0, "abort_in_done_pre");
        do_run(0, 0, 0, 6, 5, 0, 1'b0, "abort_settle");
        do_run(2, 2, 2, 5, 0, 4, 1'b0, "reset_settle");
        do_run(1, 1, 1, 1, 0, 0, 1'b0, "start_after_rst");

        do_reset(1);
        do_run(15, 0, 0, 0, 0, 0, 1'b0, "max_dur");
        do_run(0, 15, 1, 15, 0, 0, 1'b0, "max_dur_settle");
        do_run(1, 2, 3, 0, 0, 0, 1'b0, "wrap_run3");
        do_run(0, 0, 0, 1, 0, 0, 1'b0, "wrap_run4");
        do_run(2, 0, 1, 1, 0, 0, 1'b0, "wrap_run5");
        idle_steps(2, 1'b0, 1'b0, "idle_end");

        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
